// File: rtl/reset_sequencer_pkg.sv
// Shared types and width helpers for the reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    StAssert,
    StRelease,
    StRun,
    StFault
  } seq_state_e;

  // Counter must hold the larger of the assert hold time and the ready timeout.
  function automatic int unsigned cnt_width(int unsigned hold, int unsigned timeout);
    int unsigned max_val;
    max_val = (hold > timeout) ? hold : timeout;
    return $clog2(max_val + 1);
  endfunction

  // Domain index width, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_ready_sync.sv
// Two-flop synchronizer for the per-domain ready inputs.
module ready_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Capture the asynchronous ready vector through two stages; cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release across downstream domains with soft reset and timeout fault.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned ASSERT_HOLD = 16,
  parameter int unsigned STAGE_DELAY = 8,
  parameter int unsigned TIMEOUT     = 256,
  localparam int unsigned IDX_W      = idx_width(NUM_DOMAINS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sw_rst_req,
  output logic                   sw_rst_ack,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   seq_busy,
  output logic                   seq_err,
  output logic [IDX_W-1:0]       fault_idx
);

  localparam int unsigned CNT_W = cnt_width(ASSERT_HOLD, TIMEOUT);

  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(ASSERT_HOLD - 1);
  localparam logic [CNT_W-1:0] StageLast   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IdxLast     = IDX_W'(NUM_DOMAINS - 1);

  seq_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   arm_q;
  logic [NUM_DOMAINS-1:0] rst_q;
  logic                   busy_q;
  logic                   ack_q;
  logic                   err_q;
  logic [IDX_W-1:0]       fault_q;

  logic [NUM_DOMAINS-1:0] rdy_sync;
  logic                   rdy_cur;
  logic [NUM_DOMAINS-1:0] next_mask;
  logic [CNT_W-1:0]       cnt_inc;

  ready_sync #(
    .WIDTH(NUM_DOMAINS)
  ) u_ready_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_in(domain_ready),
    .sync_out(rdy_sync)
  );

  // Select the current stage's ready, build the next release mask, saturate the counter.
  always_comb begin
    rdy_cur   = 1'b0;
    next_mask = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (idx_q == IDX_W'(i)) rdy_cur = rdy_sync[i];
      next_mask[i] = (i <= int'(idx_q) + 1);
    end
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  // Sequencer FSM with counter, stage index and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      idx_q   <= '0;
      arm_q   <= 1'b1;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= '0;
    end else if (sw_rst_req) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      idx_q   <= '0;
      arm_q   <= 1'b0;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      ack_q   <= 1'b1;
      err_q   <= 1'b0;
      fault_q <= '0;
    end else begin
      ack_q <= 1'b0;
      arm_q <= 1'b0;
      case (state_q)
        StAssert: begin
          // First edge out of hard reset only re-arms, so the hold spans
          // ASSERT_HOLD edges after release just as it does after a soft reset.
          if (arm_q) begin
            cnt_q <= '0;
          end else if (cnt_q == HoldLast) begin
            state_q <= StRelease;
            rst_q   <= NUM_DOMAINS'(1);
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StRelease: begin
          // Ready is checked before timeout so a same-edge arrival advances.
          if ((cnt_q >= StageLast) && rdy_cur) begin
            if (idx_q != IdxLast) begin
              rst_q <= next_mask;
              idx_q <= idx_q + 1'b1;
              cnt_q <= '0;
            end else begin
              state_q <= StRun;
              busy_q  <= 1'b0;
            end
          end else if (cnt_q >= TimeoutLast) begin
            state_q <= StFault;
            rst_q   <= '0;
            err_q   <= 1'b1;
            fault_q <= idx_q;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StRun, StFault: begin
          // Hold until a soft or hard reset.
        end
        default: state_q <= StAssert;
      endcase
    end
  end

  assign domain_rst_n = rst_q;
  assign seq_busy     = busy_q;
  assign sw_rst_ack   = ack_q;
  assign seq_err      = err_q;
  assign fault_idx    = fault_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with an expectation queue checked after each step.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sw_req;
  logic [2:0] mask;

  logic       ack_a, busy_a, err_a;
  logic [2:0] rst_a, rdy_a;
  logic [1:0] fidx_a;

  logic       ack_b, busy_b, err_b;
  logic [2:0] rst_b;
  logic [1:0] fidx_b;

  always #5 clk = ~clk;

  assign rdy_a = rst_a & mask;

  reset_sequencer #(
    .NUM_DOMAINS(3),
    .ASSERT_HOLD(4),
    .STAGE_DELAY(2),
    .TIMEOUT    (8)
  ) dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_rst_req  (sw_req),
    .sw_rst_ack  (ack_a),
    .domain_ready(rdy_a),
    .domain_rst_n(rst_a),
    .seq_busy    (busy_a),
    .seq_err     (err_a),
    .fault_idx   (fidx_a)
  );

  reset_sequencer #(
    .NUM_DOMAINS(3),
    .ASSERT_HOLD(4),
    .STAGE_DELAY(6),
    .TIMEOUT    (8)
  ) dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .sw_rst_req  (1'b0),
    .sw_rst_ack  (ack_b),
    .domain_ready(3'b111),
    .domain_rst_n(rst_b),
    .seq_busy    (busy_b),
    .seq_err     (err_b),
    .fault_idx   (fidx_b)
  );

  typedef struct {
    string       tag;
    int          id;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   pos      = 0;
  int   base     = 0;

  localparam int RstA = 0, BusyA = 1, AckA = 2, ErrA = 3, FidxA = 4, RstB = 5, BusyB = 6;

  function automatic logic [31:0] obs(int id);
    case (id)
      RstA:    return 32'(rst_a);
      BusyA:   return 32'(busy_a);
      AckA:    return 32'(ack_a);
      ErrA:    return 32'(err_a);
      FidxA:   return 32'(fidx_a);
      RstB:    return 32'(rst_b);
      BusyB:   return 32'(busy_b);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input string tag, input int id, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.id  = id;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_now();
    exp_t        x;
    logic [31:0] o;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      o = obs(x.id);
      checks++;
      assert (o === x.exp)
      else begin
        failures++;
        $error("FAIL %s at edge %0d: observed=%0h expected=%0h", x.tag, pos, o, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic goto(input int p);
    while (pos < p) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    sw_req  = 1'b0;
    mask    = 3'b111;

    // Power-on: reset low three cycles
    repeat (3) tick();
    push("rst_domains", RstA, 3'b000);
    push("rst_busy", BusyA, 1);
    push("rst_ack", AckA, 0);
    push("rst_err", ErrA, 0);
    push("rst_fidx", FidxA, 0);
    push("rst_b_domains", RstB, 3'b000);
    check_now();
    reset_n = 1'b1;
    pos     = -1;

    goto(3);  push("pon_e3", RstA, 3'b000); check_now();
    goto(4);  push("pon_e4", RstA, 3'b001); push("b_e4", RstB, 3'b001); check_now();
    goto(6);  push("pon_e6", RstA, 3'b001); check_now();
    goto(7);  push("pon_e7", RstA, 3'b011); check_now();
    goto(9);  push("pon_e9", RstA, 3'b011); push("b_e9", RstB, 3'b001); check_now();
    goto(10); push("pon_e10", RstA, 3'b111); push("b_e10", RstB, 3'b011); check_now();
    goto(12); push("pon_busy_e12", BusyA, 1); check_now();
    goto(13); push("pon_busy_e13", BusyA, 0); push("pon_run", RstA, 3'b111); check_now();
    goto(15); push("b_e15", RstB, 3'b011); check_now();
    goto(16); push("b_e16", RstB, 3'b111); push("b_busy_e16", BusyB, 1); check_now();
    goto(22); push("b_busy_e22", BusyB, 0); check_now();

    // Ready drop in RUN is ignored
    mask = 3'b000;
    goto(26); push("run_drop_rst", RstA, 3'b111); push("run_drop_busy", BusyA, 0); check_now();

    // Soft reset pulse in RUN
    mask   = 3'b111;
    sw_req = 1'b1;
    tick();
    base   = pos;
    sw_req = 1'b0;
    push("sw_rst", RstA, 3'b000); push("sw_ack", AckA, 1); push("sw_busy", BusyA, 1);
    check_now();
    tick(); push("sw_ack_drop", AckA, 0); check_now();
    goto(base + 3); push("sw_s3", RstA, 3'b000); check_now();
    goto(base + 4); push("sw_s4", RstA, 3'b001); check_now();
    goto(base + 7); push("sw_s7", RstA, 3'b011); check_now();

    // Soft reset held five cycles while domain 1 is releasing
    sw_req = 1'b1;
    tick();
    base = pos;
    push("hold_rst", RstA, 3'b000); push("hold_ack0", AckA, 1); push("hold_err", ErrA, 0);
    check_now();
    for (int k = 1; k < 5; k++) begin
      tick();
      push("hold_ack", AckA, 1); push("hold_rst_k", RstA, 3'b000);
      check_now();
    end
    sw_req = 1'b0;
    tick(); push("hold_ack_drop", AckA, 0); check_now();
    goto(base + 7);  push("hold_m7", RstA, 3'b000); check_now();
    goto(base + 8);  push("hold_m8", RstA, 3'b001); check_now();
    goto(base + 11); push("hold_m11", RstA, 3'b011); check_now();
    goto(base + 14); push("hold_m14", RstA, 3'b111); check_now();
    goto(base + 16); push("hold_busy16", BusyA, 1); check_now();
    goto(base + 17); push("hold_busy17", BusyA, 0); check_now();

    // Timeout on domain 0 after power-on
    reset_n = 1'b0;
    mask    = 3'b110;
    repeat (3) tick();
    reset_n = 1'b1;
    pos     = -1;
    goto(4);  push("to_e4", RstA, 3'b001); check_now();
    goto(11); push("to_e11", RstA, 3'b001); push("to_err11", ErrA, 0); check_now();
    goto(12);
    push("to_rst", RstA, 3'b000); push("to_err", ErrA, 1); push("to_fidx", FidxA, 0);
    push("to_busy", BusyA, 1);
    check_now();
    goto(30); push("to_busy_hold", BusyA, 1); push("to_err_hold", ErrA, 1); check_now();

    // Soft reset out of FAULT, then timeout on domain 1
    mask   = 3'b101;
    sw_req = 1'b1;
    tick();
    base   = pos;
    sw_req = 1'b0;
    push("f_ack", AckA, 1); push("f_err_clr", ErrA, 0); push("f_fidx_clr", FidxA, 0);
    check_now();
    goto(base + 4);  push("f_s4", RstA, 3'b001); check_now();
    goto(base + 7);  push("f_s7", RstA, 3'b011); check_now();
    goto(base + 14); push("f_s14", RstA, 3'b011); push("f_err14", ErrA, 0); check_now();
    goto(base + 15);
    push("f_rst", RstA, 3'b000); push("f_err", ErrA, 1); push("f_fidx", FidxA, 1);
    push("f_busy", BusyA, 1);
    check_now();

    // Hard reset pulse in FAULT clears the error
    reset_n = 1'b0;
    tick();
    push("hr_err", ErrA, 0); push("hr_fidx", FidxA, 0); push("hr_rst", RstA, 3'b000);
    push("hr_busy", BusyA, 1);
    check_now();
    reset_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Sequences reset release across `NUM_DOMAINS` downstream reset domains, with a synchronous active-low reset on a single clock. Holds all domains in reset for a minimum time, then releases them one at a time in index order. Each release waits for the previous domain's ready indication. Also services soft-reset requests from the control plane and flags domains that never come ready; it sits between the chip-level reset conditioner and per-block reset inputs.

## Interface
- `NUM_DOMAINS`, 4: number of sequenced domains (1..16)
- `ASSERT_HOLD`, 16: minimum cycles all domains held in reset (>=1)
- `STAGE_DELAY`, 8: minimum cycles between successive domain releases (>=1)
- `TIMEOUT`, 256: cycles allowed for `domain_ready[i]` after release of domain i (>=`STAGE_DELAY`)

- `clk`  in  1  single clock; all logic on posedge
- `reset_n`  in  1  synchronous active-low reset; sampled only on `clk` posedge
- `sw_rst_req`  in  1  level soft-reset request
- `sw_rst_ack`  out  1  one-cycle pulse, request accepted
- `domain_ready`  in  NUM_DOMAINS  per-domain "out of reset and stable", asynchronous to `clk`
- `domain_rst_n`  out  NUM_DOMAINS  registered active-low reset per domain
- `seq_busy`  out  1  high while not in RUN
- `seq_err`  out  1  sticky timeout flag
- `fault_idx`  out  max(1,$clog2(NUM_DOMAINS))  domain that timed out

## Operation
- FSM states: ASSERT, RELEASE, RUN, FAULT. It uses stage index `idx` and cycle counter `cnt`, which is $clog2(max(ASSERT_HOLD,TIMEOUT)+1) bits and saturating.
- **Reset.** While `reset_n` is sampled low, the FSM goes to ASSERT with `cnt`=0 and `idx`=0.
  - Outputs in reset: `domain_rst_n`=0, `seq_busy`=1, `sw_rst_ack`=0, `seq_err`=0, `fault_idx`=0.
  - The ready synchronizer flops also clear to 0.
- **ASSERT.** All `domain_rst_n`=0; `cnt` increments each cycle.
  - On the edge where `cnt`=ASSERT_HOLD-1, go to RELEASE, set `domain_rst_n[0]`=1 and clear `cnt`.
- **RELEASE(idx).** Domains 0..idx are released; `cnt` counts edges since domain idx was released.
  - Advance when `cnt`>=STAGE_DELAY-1 and synchronized `domain_ready[idx]`=1.
  - If idx<NUM_DOMAINS-1: release domain idx+1, increment `idx`, clear `cnt`.
  - Otherwise go to RUN.
- **Timeout.** In RELEASE, if `cnt` reaches TIMEOUT-1 without ready, go to FAULT.
  - All `domain_rst_n`=0, `seq_err`=1, `fault_idx`=idx.
  - Ready arriving on that same edge wins over timeout.
- **RUN.** All `domain_rst_n`=1, `seq_busy`=0. A later drop of `domain_ready` is ignored.
- **FAULT.** All domains stay in reset and `seq_busy`=1 until a soft reset.
- **Soft reset.** `sw_rst_req`=1 is accepted in any state. On the next edge:
  - the FSM goes to ASSERT with `cnt`=0 and `idx`=0;
  - all `domain_rst_n`=0, `sw_rst_ack`=1 for that cycle, `seq_err` and `fault_idx` clear.
- **Soft reset held high.** It is re-accepted every cycle, with `ack` high continuously, so the FSM stays in ASSERT. Requesters drop the request after `ack`.
- **Priority:** `reset_n` > `sw_rst_req` > ready/advance > timeout.

## Timing
- Let E0 be the first edge sampling `reset_n`=1. `domain_rst_n[0]` rises at edge E0+ASSERT_HOLD.
- `domain_ready` passes a 2-flop synchronizer, so the FSM sees a raw rise at the 3rd edge after it.
- Domain i+1 rises at the first edge that is at least STAGE_DELAY edges after domain i's release and at which synchronized ready[i]=1.
- The FAULT edge comes exactly TIMEOUT edges after release of domain idx.
- `seq_busy` falls on the RUN entry edge and rises on the ASSERT/FAULT entry edge.
- All outputs are registered; there are no combinational input-to-output paths.
- A reset or soft reset mid-release re-asserts every domain on a single edge. No reverse ordering.

## Structure
- `reset_sequencer_pkg`: state enum (ASSERT, RELEASE, RUN, FAULT) and a `clog2`-based counter-width function.
- Sub-module `ready_sync`: NUM_DOMAINS-wide 2-flop synchronizer with synchronous active-low clear, instantiated once.
- FSM, counter and output registers live in `reset_sequencer` itself.

## Test plan
Config for all scenarios: NUM_DOMAINS=3, ASSERT_HOLD=4, STAGE_DELAY=2, TIMEOUT=8. Test 3 overrides STAGE_DELAY=6.
- **Power-on sequence.** `reset_n` low 3 cycles, then high; the bench drives `domain_ready[i]`=`domain_rst_n[i]` combinationally.
  - Domain 0 rises at E0+4, domain 1 at E0+7, domain 2 at E0+10.
  - `seq_busy` falls at E0+13.
- **Timeout.** As test 1 but `domain_ready[0]` stuck 0.
  - FAULT at E0+12: all `domain_rst_n`=0, `seq_err`=1, `fault_idx`=0.
  - `seq_busy` stays 1 indefinitely.
- **Ready early, delay dominates.** STAGE_DELAY=6, `domain_ready` tied 1 from E0.
  - Releases occur exactly 6 edges apart: E0+4, E0+10, E0+16.
- **Soft reset in RUN.** One-cycle `sw_rst_req` pulse.
  - Next edge: all `domain_rst_n`=0, `sw_rst_ack`=1 for one cycle.
  - The full sequence then repeats with domain 0 rising 4 edges later.
- **Soft reset held / mid-release.** Assert `sw_rst_req` while domain 1 is releasing and hold it 5 cycles.
  - All domains drop on the next edge and `ack` stays high for 5 cycles.
  - Domain 0 rises 4 edges after the last `ack`. A `reset_n` pulse during FAULT clears `seq_err`.
